servo_position_ramp: RTL and testbench

SERVO_POSITION_RAMP -- requirements
Module: servo_position_ramp

---
 rtl/servo_position_ramp.sv | 152 +++++++++++++++
 tb/tb_servo_position_ramp.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_position_ramp.sv
// servo_position_ramp
//   Slews a registered servo position code (duty_cycle) toward a requested
//   target at a fixed step rate. A free-running prescaler derives the step
//   tick from Main_clock. The position never moves more than one code per
//   tick and never leaves [pos_min, pos_max].
//
//   Optional feature: define SERVO_RAMP_SWEEP_EN to build the autonomous
//   sweep mode (SWEEP_UP / SWEEP_DOWN states driven by sweep_en). Without
//   the macro only IDLE and RAMP exist and sweep_en is ignored.
//
// Ports
//   Main_clock  in   1  clock, all logic on rising edge
//   reset       in   1  synchronous, active-high
//   target      in   8  requested position code
//   load        in   1  one-cycle strobe; target is sampled on the edge where
//                       load=1 (no handshake, never back-pressured)
//   sweep_en    in   1  level, requests sweep mode (sweep build only)
//   duty_cycle  out  8  registered position code to the PWM stage
//   busy        out  1  registered, high while the FSM is not in IDLE
//   at_target   out  1  registered, high in IDLE with duty_cycle == tgt_reg
//   fsm_state   out  2  debug view of the FSM state register
module servo_position_ramp #(
  parameter int in_freq = 50,
  parameter int step_hz = 200,
  parameter int pos_min = 0,
  parameter int pos_max = 255
) (
  input  logic       Main_clock,
  input  logic       reset,
  input  logic [7:0] target,
  input  logic       load,
  input  logic       sweep_en,
  output logic [7:0] duty_cycle,
  output logic       busy,
  output logic       at_target,
  output logic [1:0] fsm_state
);

  localparam longint TICK_DIV_L = (longint'(in_freq) * 64'sd1000000) / longint'(step_hz);
  localparam int     TICK_DIV   = int'(TICK_DIV_L);
  localparam int     CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0] P_MIN = 8'(pos_min);
  localparam logic [7:0] P_MAX = 8'(pos_max);

  if (TICK_DIV_L < 1 || pos_min > pos_max || pos_min < 0 || pos_max > 255) begin : g_param_check
    $error("servo_position_ramp: illegal parameters (TICK_DIV < 1 or bad position range)");
  end

`ifdef SERVO_RAMP_SWEEP_EN
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RAMP       = 2'd1,
    SWEEP_UP   = 2'd2,
    SWEEP_DOWN = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1
  } state_t;
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [7:0]       tgt_reg;
  logic [7:0]       tgt_in;
  logic [7:0]       tgt_eff;
  logic [7:0]       duty_next;
  logic             unused_sweep;

  // Keeps sweep_en formally consumed in builds without the sweep feature.
  assign unused_sweep = sweep_en;

  // Prescaler: tick is high on the wrap cycle only.
  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge Main_clock) begin
    if (reset) cnt <= '0;
    else       cnt <= tick ? '0 : cnt + 1'b1;
  end

  // Clamp in 32-bit signed arithmetic so the comparisons stay meaningful
  // when pos_min is 0 or pos_max is 255.
  always_comb begin
    tgt_in = target;
    if (int'(target) < pos_min)      tgt_in = P_MIN;
    else if (int'(target) > pos_max) tgt_in = P_MAX;
  end

  // A load takes effect in the same cycle it is presented, so retargeting
  // (including "already there") is decided against the new value.
  assign tgt_eff = load ? tgt_in : tgt_reg;

  always_comb begin
    state_next = state;
    duty_next  = duty_cycle;
    case (state)
      IDLE: begin
        if (tgt_eff != duty_cycle) state_next = RAMP;
`ifdef SERVO_RAMP_SWEEP_EN
        if (sweep_en) state_next = SWEEP_UP;
`endif
      end
      RAMP: begin
        if (tgt_eff == duty_cycle) state_next = IDLE;
        else if (tick) duty_next = (tgt_eff > duty_cycle) ? duty_cycle + 8'd1
                                                          : duty_cycle - 8'd1;
      end
`ifdef SERVO_RAMP_SWEEP_EN
      SWEEP_UP: begin
        if (!sweep_en) state_next = RAMP;
        else if (tick) begin
          // Hold for the turnaround tick at the top end.
          if (duty_cycle == P_MAX) state_next = SWEEP_DOWN;
          else                     duty_next  = duty_cycle + 8'd1;
        end
      end
      SWEEP_DOWN: begin
        if (!sweep_en) state_next = RAMP;
        else if (tick) begin
          if (duty_cycle == P_MIN) state_next = SWEEP_UP;
          else                     duty_next  = duty_cycle - 8'd1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Main_clock) begin
    if (reset) begin
      state      <= IDLE;
      duty_cycle <= P_MIN;
      tgt_reg    <= P_MIN;
      busy       <= 1'b0;
      at_target  <= 1'b1;
    end else begin
      state      <= state_next;
      duty_cycle <= duty_next;
      if (load) tgt_reg <= tgt_in;
      // Status is computed from next-state values so it lines up with the
      // state register in the same cycle.
      busy      <= (state_next != IDLE);
      at_target <= (state_next == IDLE) && (duty_next == tgt_eff);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_servo_position_ramp.sv
module tb_servo_position_ramp;

  localparam int DIV  = 4;
  localparam int PMIN = 10;
  localparam int PMAX = 20;
`ifdef SERVO_RAMP_SWEEP_EN
  localparam bit SWEEP_BUILT = 1'b1;
`else
  localparam bit SWEEP_BUILT = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] target = 8'd0;
  logic       load = 1'b0;
  logic       sweep_en = 1'b0;
  logic [7:0] duty_cycle;
  logic       busy;
  logic       at_target;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  servo_position_ramp #(
    .in_freq(1), .step_hz(250000), .pos_min(PMIN), .pos_max(PMAX)
  ) dut (
    .Main_clock(clk), .reset(reset), .target(target), .load(load),
    .sweep_en(sweep_en), .duty_cycle(duty_cycle), .busy(busy),
    .at_target(at_target), .fsm_state(fsm_state)
  );

  // behavioural reference model
  typedef enum {M_HOLD, M_SEEK, M_RISE, M_FALL} mmode_t;
  mmode_t m_mode = M_HOLD;
  int     m_pos = PMIN;
  int     m_tgt = PMIN;
  int     m_since_rst = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  bit sw_lvl   = 1'b0;
  int chg_val[$];
  int chg_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v < PMIN) return PMIN;
    if (v > PMAX) return PMAX;
    return v;
  endfunction

  // driver: one clock cycle with the given inputs, model update, checks
  task automatic step(input bit rst, input bit ld, input int tg, input bit sw);
    bit   tick;
    int   new_t;
    logic [7:0] prev;
    prev     = duty_cycle;
    reset    = rst;
    load     = ld;
    target   = tg[7:0];
    sweep_en = sw;
    tick     = 1'b0;
    if (rst) begin
      m_mode = M_HOLD; m_pos = PMIN; m_tgt = PMIN; m_since_rst = 0;
    end else begin
      // step rate: one tick on every DIV-th cycle after reset
      tick  = ((m_since_rst % DIV) == DIV - 1);
      m_since_rst++;
      new_t = ld ? clampv(tg) : m_tgt;
      case (m_mode)
        M_HOLD: begin
          if (SWEEP_BUILT && sw) m_mode = M_RISE;
          else if (new_t != m_pos) m_mode = M_SEEK;
        end
        M_SEEK: begin
          if (m_pos == new_t) m_mode = M_HOLD;
          else if (tick) m_pos += (new_t > m_pos) ? 1 : -1;
        end
        M_RISE: begin
          if (!sw) m_mode = M_SEEK;
          else if (tick) begin
            if (m_pos == PMAX) m_mode = M_FALL; else m_pos++;
          end
        end
        M_FALL: begin
          if (!sw) m_mode = M_SEEK;
          else if (tick) begin
            if (m_pos == PMIN) m_mode = M_RISE; else m_pos--;
          end
        end
      endcase
      m_tgt = new_t;
    end
    @(posedge clk);
    #1;
    cycle++;
    check("duty", 32'(duty_cycle), 32'(m_pos));
    check("busy", 32'(busy), 32'(m_mode != M_HOLD));
    check("at_target", 32'(at_target), 32'(m_mode == M_HOLD && m_pos == m_tgt));
    check("range", 32'(duty_cycle >= 8'(PMIN) && duty_cycle <= 8'(PMAX)), 32'd1);
    if (!rst) begin
      check("step_size", 32'((duty_cycle == prev) ||
                             (duty_cycle == prev + 8'd1) ||
                             (duty_cycle == prev - 8'd1)), 32'd1);
      if (!tick) check("no_step_without_tick", 32'(duty_cycle), 32'(prev));
      if (duty_cycle != prev) begin
        chg_val.push_back(int'(duty_cycle));
        chg_cyc.push_back(cycle);
      end
    end
    load = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step(1'b0, 1'b0, 0, sw_lvl);
      k++;
    end
    check({tag, "_timeout"}, 32'(busy !== 1'b0), 32'd0);
  endtask

  task automatic wait_duty(input string tag, input int val, input int budget);
    int k;
    k = 0;
    while (duty_cycle !== 8'(val) && k < budget) begin
      step(1'b0, 1'b0, 0, sw_lvl);
      k++;
    end
    check({tag, "_timeout"}, 32'(duty_cycle !== 8'(val)), 32'd0);
  endtask

  initial begin
    int k;
    // reset overrides load and sweep_en
    step(1'b1, 1'b1, 15, 1'b1);
    step(1'b1, 1'b1, 15, 1'b1);
    check("reset_duty", 32'(duty_cycle), 32'd10);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_at_target", 32'(at_target), 32'd1);
    repeat (10) step(1'b0, 1'b0, 0, 1'b0);
    check("idle_duty", 32'(duty_cycle), 32'd10);

    // ramp up to 14, one code per tick
    chg_val.delete(); chg_cyc.delete();
    step(1'b0, 1'b1, 14, 1'b0);
    check("load_busy", 32'(busy), 32'd1);
    run_until_idle("ramp14", 100);
    check("ramp14_nsteps", 32'(chg_val.size()), 32'd4);
    for (int i = 0; i < 4 && i < chg_val.size(); i++) begin
      check("ramp14_value", 32'(chg_val[i]), 32'(11 + i));
      if (i > 0) check("ramp14_spacing", 32'(chg_cyc[i] - chg_cyc[i-1]), 32'd4);
    end
    check("ramp14_at_target", 32'(at_target), 32'd1);

    // clamping at both ends
    step(1'b0, 1'b1, 200, 1'b0);
    run_until_idle("clamp_hi", 200);
    check("clamp_hi_duty", 32'(duty_cycle), 32'd20);
    step(1'b0, 1'b1, 3, 1'b0);
    run_until_idle("clamp_lo", 200);
    check("clamp_lo_duty", 32'(duty_cycle), 32'd10);

    // retarget mid-ramp reverses direction
    step(1'b0, 1'b1, 18, 1'b0);
    wait_duty("rev_reach13", 13, 100);
    chg_val.delete(); chg_cyc.delete();
    step(1'b0, 1'b1, 11, 1'b0);
    run_until_idle("rev", 100);
    check("rev_nsteps", 32'(chg_val.size()), 32'd2);
    if (chg_val.size() == 2) begin
      check("rev_first", 32'(chg_val[0]), 32'd12);
      check("rev_second", 32'(chg_val[1]), 32'd11);
    end
    check("rev_duty", 32'(duty_cycle), 32'd11);

    // retarget to the current position ends the ramp next cycle
    step(1'b0, 1'b1, 15, 1'b0);
    wait_duty("same_reach13", 13, 100);
    step(1'b0, 1'b1, 13, 1'b0);
    check("same_target_idle", 32'(busy), 32'd0);

    // reset mid-ramp aborts and restarts the prescaler
    step(1'b0, 1'b1, 20, 1'b0);
    wait_duty("abort_reach16", 16, 100);
    step(1'b1, 1'b0, 0, 1'b0);
    check("abort_duty", 32'(duty_cycle), 32'd10);
    check("abort_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b1, 11, 1'b0);
    k = 1;
    while (duty_cycle !== 8'd11 && k < 20) begin
      step(1'b0, 1'b0, 0, 1'b0);
      k++;
    end
    check("prescaler_phase", 32'(k), 32'd4);
    run_until_idle("abort_finish", 100);

`ifdef SERVO_RAMP_SWEEP_EN
    step(1'b0, 1'b1, 10, 1'b0);
    run_until_idle("sweep_prep", 100);
    chg_val.delete(); chg_cyc.delete();
    sw_lvl = 1'b1;
    k = 0;
    while (chg_val.size() < 21 && k < 300) begin
      step(1'b0, 1'b0, 0, 1'b1);
      check("sweep_busy", 32'(busy), 32'd1);
      k++;
    end
    check("sweep_nsteps", 32'(chg_val.size()), 32'd21);
    for (int i = 0; i < 21 && i < chg_val.size(); i++) begin
      int ev;
      ev = (i < 10) ? 11 + i : (i < 20) ? 29 - i : 11;
      check("sweep_value", 32'(chg_val[i]), 32'(ev));
      if (i > 0) check("sweep_spacing", 32'(chg_cyc[i] - chg_cyc[i-1]),
                       32'((i == 10 || i == 20) ? 8 : 4));
    end
    wait_duty("sweep_reach15", 15, 100);
    sw_lvl = 1'b0;
    run_until_idle("sweep_exit", 100);
    check("sweep_exit_duty", 32'(duty_cycle), 32'd10);
    check("sweep_exit_at_target", 32'(at_target), 32'd1);
`else
    repeat (20) step(1'b0, 1'b0, 0, 1'b1);
    check("sweep_ignored_busy", 32'(busy), 32'd0);
    check("sweep_ignored_duty", 32'(duty_cycle), 32'd11);
`endif

    // randomized loads, sweep requests and occasional resets
    for (int r = 0; r < 40; r++) begin
      sw_lvl = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) step(1'b1, 1'b0, 0, sw_lvl);
      else step(1'b0, 1'b1, int'($urandom_range(0, 255)), sw_lvl);
      repeat ($urandom_range(0, 30)) step(1'b0, 1'b0, 0, sw_lvl);
    end
    sw_lvl = 1'b0;
    run_until_idle("final", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
